// File: rtl/hamming_scrub_controller_if.sv
// Bus between the scrub controller, the system sequencer and the protected RAM.
// The master side is the scrubber, which drives the RAM strobes and status.
// The slave side is everything around it: sequencer commands and RAM read data.
interface hamming_scrub_controller_if #(
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
);
   logic              start;
   logic              abort;
   logic              busy;
   logic              done;
   logic              mem_rd_en;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [6:0]        mem_rd_data;
   logic [6:0]        mem_wr_data;
   logic [CNT_W-1:0]  corr_count;
   logic [ADDR_W-1:0] last_err_addr;

   modport master (
      input  start, abort, mem_rd_data,
      output busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
             corr_count, last_err_addr
   );

   modport slave (
      output start, abort, mem_rd_data,
      input  busy, done, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
             corr_count, last_err_addr
   );
endinterface

// File: rtl/hamming_scrub_controller.sv
// Scrubber for a (7,4) Hamming-protected word store.
// Walks every address once per start, corrects single-bit errors in place,
// counts the corrections (saturating) and remembers the last corrected address.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for start; counters hold the last scan's results
//   S_RD   | read strobe issued for addr
//   S_CHK  | read data valid; syndrome decides write-back or next word
//   S_WR   | corrected word written back to addr
//   S_DONE | one-cycle done pulse after the last word
//
// Word layout h[6:0] = D7 D6 D5 P4 D3 P2 P1; syndrome S = {s2,s1,s0} points
// at the faulty bit position (1..7), zero means clean.
module hamming_scrub_controller #(
   parameter int ADDR_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic clk,
   input  logic rst,
   hamming_scrub_controller_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CHK  = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   state_t            state, state_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [6:0]        word, word_n;
   logic [CNT_W-1:0]  count, count_n;
   logic [ADDR_W-1:0] last_addr, last_addr_n;

   logic [2:0]        syn;
   logic [6:0]        fixed_word;

   // Syndrome of the word currently returned by the RAM and its single-bit fix.
   always_comb begin
      syn[0]     = bus.mem_rd_data[0] ^ bus.mem_rd_data[2] ^ bus.mem_rd_data[4] ^ bus.mem_rd_data[6];
      syn[1]     = bus.mem_rd_data[1] ^ bus.mem_rd_data[2] ^ bus.mem_rd_data[5] ^ bus.mem_rd_data[6];
      syn[2]     = bus.mem_rd_data[3] ^ bus.mem_rd_data[4] ^ bus.mem_rd_data[5] ^ bus.mem_rd_data[6];
      fixed_word = bus.mem_rd_data;
      if (syn != 3'd0) begin
         fixed_word = bus.mem_rd_data ^ (7'd1 << (syn - 3'd1));
      end
   end

   // State and datapath registers; reset drops any write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         addr      <= '0;
         word      <= '0;
         count     <= '0;
         last_addr <= '0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         word      <= word_n;
         count     <= count_n;
         last_addr <= last_addr_n;
      end
   end

   // Next-state and datapath update; abort is only looked at while scanning.
   always_comb begin
      state_n     = state;
      addr_n      = addr;
      word_n      = word;
      count_n     = count;
      last_addr_n = last_addr;

      case (state)
         S_IDLE: begin
            if (bus.start) begin
               count_n = '0;
               addr_n  = '0;
               state_n = S_RD;
            end
         end

         S_RD: begin
            if (bus.abort) begin
               state_n = S_IDLE;
            end else begin
               state_n = S_CHK;
            end
         end

         S_CHK: begin
            if (bus.abort) begin
               state_n = S_IDLE;
            end else if (syn != 3'd0) begin
               word_n  = fixed_word;
               state_n = S_WR;
            end else if (addr == ADDR_LAST) begin
               state_n = S_DONE;
            end else begin
               addr_n  = addr + ADDR_ONE;
               state_n = S_RD;
            end
         end

         S_WR: begin
            // The write strobe of this cycle always completes, so the
            // bookkeeping follows it even when the scan is being aborted.
            if (count != CNT_MAX) begin
               count_n = count + CNT_ONE;
            end
            last_addr_n = addr;
            if (bus.abort) begin
               state_n = S_IDLE;
            end else if (addr == ADDR_LAST) begin
               state_n = S_DONE;
            end else begin
               addr_n  = addr + ADDR_ONE;
               state_n = S_RD;
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // Outputs are pure decodes of state and registers.
   always_comb begin
      bus.busy          = (state == S_RD) || (state == S_CHK) || (state == S_WR);
      bus.done          = (state == S_DONE);
      bus.mem_rd_en     = (state == S_RD);
      bus.mem_wr_en     = (state == S_WR);
      bus.mem_addr      = addr;
      bus.mem_wr_data   = word;
      bus.corr_count    = count;
      bus.last_err_addr = last_addr;
   end

endmodule

// File: tb/tb_hamming_scrub_controller.sv
// Bench for the Hamming scrub controller: two instances (8-bit and 2-bit
// correction counters), each with a registered-read RAM model.
module tb_hamming_scrub_controller;

   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   hamming_scrub_controller_if #(.ADDR_W(4), .CNT_W(8)) ifa ();
   hamming_scrub_controller_if #(.ADDR_W(4), .CNT_W(2)) ifb ();

   hamming_scrub_controller #(.ADDR_W(4), .CNT_W(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   hamming_scrub_controller #(.ADDR_W(4), .CNT_W(2)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   logic [6:0] mem_a [16];
   logic [6:0] mem_b [16];
   logic [6:0] init_w [16];
   logic       load_a;
   logic       load_b;

   // RAM models: read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (load_a) begin
         for (int i = 0; i < 16; i++) mem_a[i] <= init_w[i];
      end else if (ifa.mem_wr_en) begin
         mem_a[ifa.mem_addr] <= ifa.mem_wr_data;
      end
      if (rst) ifa.mem_rd_data <= 7'd0;
      else if (ifa.mem_rd_en) ifa.mem_rd_data <= mem_a[ifa.mem_addr];
   end

   always @(posedge clk) begin
      if (load_b) begin
         for (int i = 0; i < 16; i++) mem_b[i] <= init_w[i];
      end else if (ifb.mem_wr_en) begin
         mem_b[ifb.mem_addr] <= ifb.mem_wr_data;
      end
      if (rst) ifb.mem_rd_data <= 7'd0;
      else if (ifb.mem_rd_en) ifb.mem_rd_data <= mem_b[ifb.mem_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [6:0] h;
      h[6] = d[3];
      h[5] = d[2];
      h[4] = d[1];
      h[2] = d[0];
      h[0] = d[0] ^ d[1] ^ d[3];
      h[1] = d[0] ^ d[2] ^ d[3];
      h[3] = d[1] ^ d[2] ^ d[3];
      return h;
   endfunction

   task automatic load_mem(input bit sel);
      @(negedge clk);
      if (sel) load_b = 1'b1;
      else     load_a = 1'b1;
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
   endtask

   task automatic clear_init();
      for (int i = 0; i < 16; i++) init_w[i] = 7'd0;
   endtask

   int         wl_addr [$];
   logic [6:0] wl_data [$];
   int         busy_n;
   int         done_n;
   int         post_busy;

   task automatic drive_start(input bit sel, input logic v);
      if (sel) ifb.start = v;
      else     ifa.start = v;
   endtask

   // Pulse start, then follow the scan to its done pulse, logging writes.
   task automatic scan(input bit sel, input int glitch_addr, input bit start_in_done);
      bit got_done;
      logic b, d, we, re;
      int   a;
      logic [6:0] wd;
      wl_addr.delete();
      wl_data.delete();
      busy_n    = 0;
      done_n    = 0;
      post_busy = 0;
      got_done  = 1'b0;
      @(negedge clk);
      drive_start(sel, 1'b1);
      @(negedge clk);
      drive_start(sel, 1'b0);
      for (int c = 0; c < 200 && !got_done; c++) begin
         b  = sel ? ifb.busy      : ifa.busy;
         d  = sel ? ifb.done      : ifa.done;
         we = sel ? ifb.mem_wr_en : ifa.mem_wr_en;
         re = sel ? ifb.mem_rd_en : ifa.mem_rd_en;
         a  = int'(sel ? ifb.mem_addr : ifa.mem_addr);
         wd = sel ? ifb.mem_wr_data : ifa.mem_wr_data;
         drive_start(sel, (glitch_addr >= 0) && re && (a == glitch_addr));
         if (b) busy_n++;
         if (we) begin
            wl_addr.push_back(a);
            wl_data.push_back(wd);
         end
         if (d) begin
            done_n++;
            got_done = 1'b1;
            drive_start(sel, start_in_done);
            @(negedge clk);
            drive_start(sel, 1'b0);
            if (sel ? ifb.done : ifa.done) done_n++;
            post_busy = int'(sel ? ifb.busy : ifa.busy);
         end else begin
            @(negedge clk);
         end
      end
      if (!got_done) check("scan_timeout", 0, 1);
   endtask

   typedef struct {
      logic [6:0] stored;
      logic [6:0] fixed;
      bit         wr;
   } vec_t;

   vec_t vec [16];

   initial begin
      int ncorr;
      int last;
      int idx;
      bit found;
      int seen;

      rst       = 1'b1;
      load_a    = 1'b0;
      load_b    = 1'b0;
      ifa.start = 1'b0;
      ifa.abort = 1'b0;
      ifb.start = 1'b0;
      ifb.abort = 1'b0;
      clear_init();

      // Reset state
      #12;
      check("rst_busy",    32'(ifa.busy), 0);
      check("rst_done",    32'(ifa.done), 0);
      check("rst_rd_en",   32'(ifa.mem_rd_en), 0);
      check("rst_wr_en",   32'(ifa.mem_wr_en), 0);
      check("rst_addr",    32'(ifa.mem_addr), 0);
      check("rst_wr_data", 32'(ifa.mem_wr_data), 0);
      check("rst_corr",    32'(ifa.corr_count), 0);
      check("rst_last",    32'(ifa.last_err_addr), 0);
      check("rst_b_corr",  32'(ifb.corr_count), 0);
      @(negedge clk);
      rst = 1'b0;

      // Clean codewords everywhere; a start during DONE must be ignored
      for (int i = 0; i < 16; i++) init_w[i] = enc(4'(i));
      load_mem(0);
      scan(0, -1, 1);
      check("clean_busy_cycles", busy_n, 32);
      check("clean_writes", wl_addr.size(), 0);
      check("clean_done_cycles", done_n, 1);
      check("clean_corr", 32'(ifa.corr_count), 0);
      check("start_in_done_ignored", post_busy, 0);

      // Table-driven mixed scan, with a start pulse in the middle of it
      vec[0]  = '{7'h00, 7'h00, 0};
      vec[1]  = '{7'h07, 7'h07, 0};
      vec[2]  = '{7'h47, 7'h07, 1};
      vec[3]  = '{7'h4B, 7'h4B, 0};
      vec[4]  = '{7'h4A, 7'h4B, 1};
      vec[5]  = '{7'h33, 7'h33, 0};
      vec[6]  = '{7'h3B, 7'h33, 1};
      vec[7]  = '{7'h7F, 7'h7F, 0};
      vec[8]  = '{7'h6F, 7'h7F, 1};
      vec[9]  = '{7'h20, 7'h00, 1};
      vec[10] = '{7'h07, 7'h07, 0};
      vec[11] = '{7'h01, 7'h00, 1};
      vec[12] = '{7'h33, 7'h33, 0};
      vec[13] = '{7'h4B, 7'h4B, 0};
      vec[14] = '{7'h7E, 7'h7F, 1};
      vec[15] = '{7'h7F, 7'h7F, 0};
      for (int i = 0; i < 16; i++) init_w[i] = vec[i].stored;
      load_mem(0);
      scan(0, 10, 0);
      ncorr = 0;
      last  = 0;
      idx   = 0;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("vec%0d_mem", i), 32'(mem_a[i]), 32'(vec[i].fixed));
         found = (idx < wl_addr.size()) && (wl_addr[idx] == i);
         check($sformatf("vec%0d_write", i), 32'(found), 32'(vec[i].wr));
         if (found) begin
            check($sformatf("vec%0d_wdata", i), 32'(wl_data[idx]), 32'(vec[i].fixed));
            idx++;
         end
         if (vec[i].wr) begin
            ncorr++;
            last = i;
         end
      end
      check("vec_writes", wl_addr.size(), ncorr);
      check("vec_corr", 32'(ifa.corr_count), ncorr);
      check("vec_last", 32'(ifa.last_err_addr), last);
      check("vec_busy_cycles", busy_n, 32 + ncorr);
      check("vec_done_cycles", done_n, 1);

      // Single error at addr 5
      clear_init();
      init_w[5] = 7'b0000100;
      load_mem(0);
      scan(0, -1, 0);
      check("one_writes", wl_addr.size(), 1);
      if (wl_addr.size() > 0) begin
         check("one_waddr", wl_addr[0], 5);
         check("one_wdata", 32'(wl_data[0]), 0);
      end
      check("one_corr", 32'(ifa.corr_count), 1);
      check("one_last", 32'(ifa.last_err_addr), 5);
      check("one_busy_cycles", busy_n, 33);

      // Every syndrome value 1..7
      clear_init();
      for (int k = 1; k < 8; k++) init_w[k] = 7'(1 << (k - 1));
      load_mem(0);
      scan(0, -1, 0);
      check("syn_writes", wl_addr.size(), 7);
      for (int j = 0; j < wl_data.size(); j++) begin
         check($sformatf("syn_wdata%0d", j), 32'(wl_data[j]), 0);
         check($sformatf("syn_waddr%0d", j), wl_addr[j], j + 1);
      end
      check("syn_corr", 32'(ifa.corr_count), 7);
      check("syn_last", 32'(ifa.last_err_addr), 7);

      // 2-bit counter saturates at 3
      clear_init();
      init_w[0]  = 7'h01;
      init_w[3]  = 7'h02;
      init_w[6]  = 7'h10;
      init_w[9]  = 7'h40;
      init_w[15] = 7'h08;
      load_mem(1);
      scan(1, -1, 0);
      check("sat_writes", wl_addr.size(), 5);
      check("sat_corr", 32'(ifb.corr_count), 3);
      check("sat_last", 32'(ifb.last_err_addr), 15);
      check("sat_mem15", 32'(mem_b[15]), 0);

      // Abort in RD of addr 8, then a fresh scan from addr 0
      clear_init();
      init_w[2] = 7'b0000100;
      load_mem(0);
      @(negedge clk);
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (ifa.mem_rd_en && ifa.mem_addr == 4'd8) found = 1'b1;
         else @(negedge clk);
      end
      check("abort_reached_addr8", 32'(found), 1);
      ifa.abort = 1'b1;
      @(negedge clk);
      ifa.abort = 1'b0;
      check("abort_busy", 32'(ifa.busy), 0);
      check("abort_done", 32'(ifa.done), 0);
      check("abort_addr_kept", 32'(ifa.mem_addr), 8);
      check("abort_corr", 32'(ifa.corr_count), 1);
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (ifa.done || ifa.busy) seen++;
      end
      check("abort_stays_idle", seen, 0);
      scan(0, -1, 0);
      check("rescan_busy_cycles", busy_n, 32);
      check("rescan_corr", 32'(ifa.corr_count), 0);
      check("rescan_done_cycles", done_n, 1);

      // Abort during WR still writes and counts
      clear_init();
      init_w[4] = 7'h01;
      load_mem(0);
      @(negedge clk);
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (ifa.mem_wr_en) found = 1'b1;
         else @(negedge clk);
      end
      check("wr_abort_reached", 32'(found), 1);
      ifa.abort = 1'b1;
      @(negedge clk);
      ifa.abort = 1'b0;
      check("wr_abort_busy", 32'(ifa.busy), 0);
      check("wr_abort_corr", 32'(ifa.corr_count), 1);
      check("wr_abort_last", 32'(ifa.last_err_addr), 4);
      check("wr_abort_addr", 32'(ifa.mem_addr), 4);
      check("wr_abort_mem", 32'(mem_a[4]), 0);

      // Reset in the middle of the second write
      clear_init();
      init_w[1] = 7'h01;
      init_w[3] = 7'h02;
      load_mem(0);
      @(negedge clk);
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (ifa.mem_wr_en && ifa.mem_addr == 4'd3) found = 1'b1;
         else @(negedge clk);
      end
      check("rst_wr_reached", 32'(found), 1);
      check("rst_wr_corr_before", 32'(ifa.corr_count), 1);
      #1 rst = 1'b1;
      #1;
      check("rst_wr_wr_en", 32'(ifa.mem_wr_en), 0);
      check("rst_wr_busy", 32'(ifa.busy), 0);
      check("rst_wr_corr", 32'(ifa.corr_count), 0);
      check("rst_wr_last", 32'(ifa.last_err_addr), 0);
      check("rst_wr_addr", 32'(ifa.mem_addr), 0);
      @(negedge clk);
      rst = 1'b0;
      check("rst_wr_dropped", 32'(mem_a[3]), 7'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
